// File: rtl/key_sel_pkg.sv
// Shared types, defaults and helpers for the key-driven 2-bit selection stepper.
package key_sel_pkg;

    localparam int NUM_KEYS            = 2;
    localparam int KEY_UP              = 0;
    localparam int KEY_DOWN            = 1;
    localparam int DEF_DEBOUNCE_CYCLES = 50000;
    localparam int DEF_REPEAT_DELAY    = 25000000;
    localparam int DEF_REPEAT_PERIOD   = 5000000;

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_e;
    typedef enum logic {UP, DOWN} dir_e;

    // Counter width for a counter running 0 .. n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Wrapping one-position move of the 2-bit selection.
    function automatic logic [1:0] step_sel(input logic [1:0] cur, input dir_e dir);
        return (dir == UP) ? cur + 2'd1 : cur - 2'd1;
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// Two-flop synchroniser followed by a run-length debounce filter for one raw button.
module key_debouncer
    import key_sel_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level
);

    localparam int              CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            cnt_q  <= '0;
            level  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], raw};
            // Any sample agreeing with the accepted level restarts the run.
            if (sync_q[1] == level) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                level <= ~level;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/key_sel_stepper.sv
// Debounced up/down buttons stepping a wrapping 2-bit selection, with hold-to-repeat
// and a one-cycle strobe on every selection update.
module key_sel_stepper
    import key_sel_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       clear,
    output logic [1:0] sel,
    output logic       sel_strobe,
    output logic [1:0] keys_db
);

    localparam int            TMAX        = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int            TW          = cnt_width(TMAX);
    localparam bit            REPEAT_EN   = (REPEAT_DELAY > 0);
    localparam logic [TW-1:0] DELAY_LAST  = REPEAT_EN ? TW'(REPEAT_DELAY - 1) : '0;
    localparam logic [TW-1:0] PERIOD_LAST = TW'(REPEAT_PERIOD - 1);

    logic [NUM_KEYS-1:0] raw_keys;
    logic [NUM_KEYS-1:0] keys_db_q;
    logic [NUM_KEYS-1:0] press;

    assign raw_keys = {key_down, key_up};

    genvar g;
    generate
        for (g = 0; g < NUM_KEYS; g++) begin : g_key
            key_debouncer #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_db (
                .clock (clock),
                .reset (reset),
                .raw   (raw_keys[g]),
                .level (keys_db[g])
            );
        end
    endgenerate

    assign press = keys_db & ~keys_db_q;

    state_e        state_q, state_d;
    dir_e          dir_q, dir_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          step;
    logic          active_held;
    logic          clear_q;
    logic [1:0]    sel_d;
    logic          strobe_d;

    assign active_held = (dir_q == UP) ? keys_db[KEY_UP] : keys_db[KEY_DOWN];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            dir_q      <= UP;
            timer_q    <= '0;
            keys_db_q  <= '0;
            clear_q    <= 1'b0;
            sel        <= 2'd0;
            sel_strobe <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            timer_q    <= timer_d;
            keys_db_q  <= keys_db;
            clear_q    <= clear;
            sel        <= sel_d;
            sel_strobe <= strobe_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        timer_d = timer_q;
        step    = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Two simultaneous presses cancel each other out.
                if (press[KEY_UP] ^ press[KEY_DOWN]) begin
                    step    = 1'b1;
                    dir_d   = press[KEY_UP] ? UP : DOWN;
                    timer_d = '0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (!active_held) begin
                    state_d = IDLE;
                end else if (REPEAT_EN && timer_q == DELAY_LAST) begin
                    step    = 1'b1;
                    timer_d = '0;
                    state_d = REPEAT;
                end else if (REPEAT_EN) begin
                    timer_d = timer_q + 1'b1;
                end
            end
            REPEAT: begin
                if (!active_held) begin
                    state_d = IDLE;
                end else if (timer_q == PERIOD_LAST) begin
                    step    = 1'b1;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Clear wins over a coincident step; only its first cycle produces a strobe.
    always_comb begin
        sel_d    = sel;
        strobe_d = 1'b0;
        if (clear) begin
            sel_d    = 2'd0;
            strobe_d = ~clear_q;
        end else if (step) begin
            sel_d    = step_sel(sel, dir_d);
            strobe_d = 1'b1;
        end
    end

endmodule
